// File: rtl/conv_weight_bank_if.sv
// conv_weight_bank_if
//   Bundles the weight-stream, swap, read and status signals of the
//   double-buffered kernel weight bank.
//   master : weight source / conv datapath side (drives in_*, swap, rd_*, clear)
//   slave  : the weight bank itself
//   Signals:
//     clear        synchronous soft clear (both banks invalid, load aborted)
//     in_valid/in_ready/in_data   serial weight stream into the shadow bank
//     load_done    1-cycle pulse when the last weight of a set is accepted
//     shadow_full  shadow bank holds a complete set
//     swap         request to make the shadow set active
//     act_valid    active bank holds a valid set
//     rd_en/rd_ch  read request for one channel kernel
//     weights_out/out_valid/out_ch  registered read result
//     err          1-cycle pulse on a rejected swap or read
interface conv_weight_bank_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL     = 3,
    parameter int NUM_CH     = 4
);
    localparam int KK   = KERNEL * KERNEL;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic                     clear;
    logic                     in_valid;
    logic                     in_ready;
    logic [DATA_WIDTH-1:0]    in_data;
    logic                     load_done;
    logic                     shadow_full;
    logic                     swap;
    logic                     act_valid;
    logic                     rd_en;
    logic [CH_W-1:0]          rd_ch;
    logic [KK*DATA_WIDTH-1:0] weights_out;
    logic                     out_valid;
    logic [CH_W-1:0]          out_ch;
    logic                     err;

    modport master (
        output clear, in_valid, in_data, swap, rd_en, rd_ch,
        input  in_ready, load_done, shadow_full, act_valid,
               weights_out, out_valid, out_ch, err
    );

    modport slave (
        input  clear, in_valid, in_data, swap, rd_en, rd_ch,
        output in_ready, load_done, shadow_full, act_valid,
               weights_out, out_valid, out_ch, err
    );
endinterface

// File: rtl/conv_weight_bank.sv
// conv_weight_bank
//   Ping-pong kernel weight store. A full set of NUM_CH x KERNEL x KERNEL
//   weights is streamed serially into the shadow bank while the conv
//   datapath reads whole per-channel kernels from the active bank. A swap
//   makes the freshly loaded set active without a reload stall.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous, active-high reset
//     bus  conv_weight_bank_if.slave (stream in, swap, read, status)
//   Storage: each channel kernel is one KK*DATA_WIDTH word so a whole
//   kernel is read in one cycle; the serial write path drops each weight
//   into its lane of the word (per-lane write enable).
module conv_weight_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int KERNEL     = 3,
    parameter int NUM_CH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    conv_weight_bank_if.slave bus
);
    localparam int KK     = KERNEL * KERNEL;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int POS_W  = (KK > 1) ? $clog2(KK) : 1;
    localparam int WORD_W = KK * DATA_WIDTH;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(KK - 1);
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);

    // Two banks of NUM_CH kernel words; not reset.
    logic [WORD_W-1:0] mem [2][NUM_CH];

    logic              act_sel;
    logic              act_valid;
    logic              shadow_full;
    // Write address split as (channel, position in kernel); together they
    // form the linear weight counter 0..TOTAL-1.
    logic [CH_W-1:0]   wr_ch;
    logic [POS_W-1:0]  wr_pos;

    logic              load_done_q;
    logic              err_q;
    logic              out_valid_q;
    logic [CH_W-1:0]   out_ch_q;
    logic [WORD_W-1:0] weights_q;

    logic              wr_fire;
    logic              wr_last;
    logic              rd_ok;
    logic              rd_bad;
    logic              swap_ok;
    logic              swap_bad;

    always_comb begin
        wr_fire  = bus.in_valid && !shadow_full && !bus.clear;
        wr_last  = (wr_ch == LAST_CH) && (wr_pos == LAST_POS);
        rd_ok    = bus.rd_en && act_valid && ({1'b0, bus.rd_ch} < NUM_CH_L);
        rd_bad   = bus.rd_en && !rd_ok;
        swap_ok  = bus.swap && shadow_full;
        swap_bad = bus.swap && !shadow_full;
    end

    // Shadow bank is the one not selected for reading.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[!act_sel][wr_ch][int'(wr_pos)*DATA_WIDTH +: DATA_WIDTH] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_sel     <= 1'b0;
            act_valid   <= 1'b0;
            shadow_full <= 1'b0;
            wr_ch       <= '0;
            wr_pos      <= '0;
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            weights_q   <= '0;
        end else begin
            load_done_q <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            if (bus.clear) begin
                act_valid   <= 1'b0;
                shadow_full <= 1'b0;
                wr_ch       <= '0;
                wr_pos      <= '0;
            end else begin
                // Read samples act_sel before any swap in this edge takes effect.
                if (rd_ok) begin
                    weights_q   <= mem[act_sel][bus.rd_ch];
                    out_ch_q    <= bus.rd_ch;
                    out_valid_q <= 1'b1;
                end
                if (swap_ok) begin
                    act_sel     <= !act_sel;
                    act_valid   <= 1'b1;
                    shadow_full <= 1'b0;
                end
                err_q <= rd_bad || swap_bad;
                // A write can only fire while the shadow is not full, so it
                // never coincides with an accepted swap.
                if (wr_fire) begin
                    if (wr_last) begin
                        wr_ch       <= '0;
                        wr_pos      <= '0;
                        shadow_full <= 1'b1;
                        load_done_q <= 1'b1;
                    end else if (wr_pos == LAST_POS) begin
                        wr_pos <= '0;
                        wr_ch  <= wr_ch + 1'b1;
                    end else begin
                        wr_pos <= wr_pos + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.in_ready    = !shadow_full;
        bus.load_done   = load_done_q;
        bus.shadow_full = shadow_full;
        bus.act_valid   = act_valid;
        bus.weights_out = weights_q;
        bus.out_valid   = out_valid_q;
        bus.out_ch      = out_ch_q;
        bus.err         = err_q;
    end
endmodule

// File: tb/tb_conv_weight_bank.sv
// tb_conv_weight_bank
//   Self-checking bench for conv_weight_bank. Instance A (DW=8, K=3, CH=2)
//   is driven by directed scenarios and random traffic and compared every
//   cycle with a set-level reference model. Instance B (DW=16, K=5, CH=4)
//   checks wide packing; instance C (CH=3) checks out-of-range channels.
module tb_conv_weight_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    conv_weight_bank_if #(.DATA_WIDTH(8),  .KERNEL(3), .NUM_CH(2)) wa ();
    conv_weight_bank_if #(.DATA_WIDTH(16), .KERNEL(5), .NUM_CH(4)) wb ();
    conv_weight_bank_if #(.DATA_WIDTH(8),  .KERNEL(3), .NUM_CH(3)) wc ();

    conv_weight_bank #(.DATA_WIDTH(8),  .KERNEL(3), .NUM_CH(2)) u_a (.clk(clk), .rst(rst), .bus(wa));
    conv_weight_bank #(.DATA_WIDTH(16), .KERNEL(5), .NUM_CH(4)) u_b (.clk(clk), .rst(rst), .bus(wb));
    conv_weight_bank #(.DATA_WIDTH(8),  .KERNEL(3), .NUM_CH(3)) u_c (.clk(clk), .rst(rst), .bus(wc));

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model for instance A ----------------
    localparam int AKK  = 9;
    localparam int ATOT = 18;
    int         a_act [ATOT];   // weights of the set currently readable
    int         a_sh  [ATOT];   // completed set waiting for a swap
    int         a_ld  [ATOT];   // weights accepted for the load in progress
    int         a_n;
    bit         a_valid, a_full, a_ov, a_err, a_done;
    logic [71:0] a_w;
    logic       a_och;

    function automatic logic [71:0] a_pack(input int ch);
        logic [71:0] r;
        int v;
        for (int i = 0; i < AKK; i++) begin
            v = a_act[ch*AKK+i];
            r[i*8 +: 8] = v[7:0];
        end
        return r;
    endfunction

    task automatic a_reset_model();
        a_n = 0; a_valid = 0; a_full = 0;
        a_ov = 0; a_err = 0; a_done = 0;
        a_w = '0; a_och = 1'b0;
    endtask

    task automatic a_step();
        bit fire;
        int ch;
        a_ov = 0; a_err = 0; a_done = 0;
        if (wa.clear) begin
            a_valid = 0; a_full = 0; a_n = 0;
        end else begin
            fire = wa.in_valid && !a_full;
            ch = int'(wa.rd_ch);
            if (wa.rd_en) begin
                if (a_valid && ch < 2) begin
                    a_w = a_pack(ch); a_och = wa.rd_ch; a_ov = 1;
                end else a_err = 1;
            end
            if (wa.swap) begin
                if (a_full) begin
                    a_act = a_sh; a_valid = 1; a_full = 0;
                end else a_err = 1;
            end
            if (fire) begin
                a_ld[a_n] = int'(wa.in_data);
                a_n++;
                if (a_n == ATOT) begin
                    a_sh = a_ld; a_full = 1; a_done = 1; a_n = 0;
                end
            end
        end
        @(posedge clk); #1;
        check("a_in_ready",    wa.in_ready,    !a_full);
        check("a_shadow_full", wa.shadow_full, a_full);
        check("a_act_valid",   wa.act_valid,   a_valid);
        check("a_load_done",   wa.load_done,   a_done);
        check("a_out_valid",   wa.out_valid,   a_ov);
        check("a_err",         wa.err,         a_err);
        check("a_out_ch",      wa.out_ch,      a_och);
        check("a_weights",     wa.weights_out, a_w);
    endtask

    task automatic a_cyc(input bit v, input int d, input bit sw, input bit re, input int ch, input bit clr);
        wa.in_valid = v;
        wa.in_data  = d[7:0];
        wa.swap     = sw;
        wa.rd_en    = re;
        wa.rd_ch    = ch[0:0];
        wa.clear    = clr;
        a_step();
    endtask

    task automatic idle_all();
        wa.in_valid = 0; wa.in_data = '0; wa.swap = 0; wa.rd_en = 0; wa.rd_ch = '0; wa.clear = 0;
        wb.in_valid = 0; wb.in_data = '0; wb.swap = 0; wb.rd_en = 0; wb.rd_ch = '0; wb.clear = 0;
        wc.in_valid = 0; wc.in_data = '0; wc.swap = 0; wc.rd_en = 0; wc.rd_ch = '0; wc.clear = 0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        a_reset_model();
        check("rst_in_ready",  {wa.in_ready, wb.in_ready, wc.in_ready}, 3'b111);
        check("rst_flags",     {wa.load_done, wa.shadow_full, wa.act_valid, wa.out_valid, wa.err}, 5'b0);
        check("rst_weights_a", wa.weights_out, 72'h0);
        check("rst_weights_b", wb.weights_out, 400'h0);
        check("rst_out_ch_b",  wb.out_ch, 2'd0);
    endtask

    // Streams a full set starting at value base; random stalls if stall=1.
    task automatic a_load(input int base, input bit stall);
        int k = 0;
        int guard = 0;
        bit v, f;
        while (k < ATOT && guard < 200) begin
            v = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            f = v && !a_full;
            a_cyc(v, base + k, 0, 0, 0, 0);
            if (f) k++;
            guard++;
        end
        if (k < ATOT) check("a_load_timeout", k, ATOT);
    endtask

    logic [15:0] bv [100];

    initial begin
        int k, guard;
        bit v, f;
        logic [399:0] bexp;
        logic [71:0]  cexp;

        a_reset_model();
        do_reset();

        // Scenario 1/2: continuous load, swap, read both channels.
        a_load(1, 0);
        check("s1_full_after_load", wa.shadow_full, 1'b1);
        a_cyc(0, 0, 0, 0, 0, 0);
        a_cyc(0, 0, 1, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 1, 0);
        check("s2_ch1_bytes", wa.weights_out, 72'h12_11_10_0f_0e_0d_0c_0b_0a);
        a_cyc(0, 0, 0, 1, 0, 0);
        check("s2_ch0_bytes", wa.weights_out, 72'h09_08_07_06_05_04_03_02_01);

        // Scenario 3: reload with stalls while reading every cycle.
        k = 101; guard = 0;
        while (!a_full && guard < 200) begin
            v = ($urandom_range(0, 3) != 0);
            f = v && !a_full;
            a_cyc(v, k, 0, 1, $urandom_range(0, 1), 0);
            if (f) k++;
            guard++;
        end
        if (!a_full) check("s3_timeout", a_full, 1'b1);
        repeat (3) a_cyc(1, 8'hEE, 0, 1, 0, 0);   // ignored while full
        a_cyc(0, 0, 1, 1, 1, 0);                   // read + swap: old set
        check("s3_old_set", wa.weights_out, 72'h12_11_10_0f_0e_0d_0c_0b_0a);
        a_cyc(0, 0, 0, 1, 0, 0);
        check("s3_new_set", wa.weights_out, 72'h6d_6c_6b_6a_69_68_67_66_65);

        // Scenario 4: rejected reads and swaps.
        do_reset();
        a_cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) a_cyc(1, 30 + i, 0, 0, 0, 0);
        a_cyc(0, 0, 1, 0, 0, 0);
        for (int i = 5; i < 17; i++) a_cyc(1, 30 + i, 0, 0, 0, 0);
        a_cyc(1, 47, 1, 0, 0, 0);                  // last weight + swap
        a_cyc(0, 0, 1, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 1, 0);

        // Scenario 5: async reset mid-load, then clean reload.
        for (int i = 0; i < 7; i++) a_cyc(1, 90 + i, 0, 0, 0, 0);
        wa.in_valid = 0;
        rst = 1'b1;
        #2;
        check("s5_async_act_valid", wa.act_valid, 1'b0);
        check("s5_async_in_ready",  wa.in_ready, 1'b1);
        a_reset_model();
        #1 rst = 1'b0;
        a_load(200, 1);
        a_cyc(0, 0, 1, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 0, 0);
        check("s5_ch0", wa.weights_out, 72'hd0_cf_ce_cd_cc_cb_ca_c9_c8);
        a_cyc(0, 0, 0, 1, 1, 0);
        check("s5_ch1", wa.weights_out, 72'hd9_d8_d7_d6_d5_d4_d3_d2_d1);
        a_load(50, 0);
        a_cyc(0, 0, 0, 0, 0, 1);                   // clear after full load
        check("s5_clear_flags", {wa.act_valid, wa.shadow_full}, 2'b00);
        for (int i = 0; i < 4; i++) a_cyc(1, 70 + i, 0, 0, 0, 0);
        a_cyc(0, 0, 0, 0, 0, 1);                   // clear mid-load
        a_load(150, 1);
        a_cyc(0, 0, 1, 0, 0, 0);
        a_cyc(0, 0, 0, 1, 0, 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            a_cyc($urandom_range(0, 1), $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 63) == 0);
        end
        idle_all();

        // Instance B: DW=16, K=5, CH=4, TOTAL=100.
        for (int i = 0; i < 100; i++) bv[i] = 16'($urandom);
        do_reset();
        k = 0; guard = 0;
        while (k < 100 && guard < 1000) begin
            wb.in_valid = ($urandom_range(0, 2) != 0);
            wb.in_data  = bv[k];
            f = wb.in_valid && wb.in_ready;
            @(posedge clk); #1;
            if (f) k++;
            check("b_load_done", wb.load_done, f && k == 100);
            guard++;
        end
        if (k < 100) check("b_load_timeout", k, 100);
        wb.in_valid = 0;
        check("b_full", {wb.shadow_full, wb.in_ready, wb.act_valid}, 3'b100);
        wb.swap = 1;
        @(posedge clk); #1;
        wb.swap = 0;
        check("b_swap", {wb.act_valid, wb.shadow_full, wb.in_ready}, 3'b101);
        for (int ch = 0; ch < 4; ch++) begin
            for (int i = 0; i < 25; i++) bexp[i*16 +: 16] = bv[ch*25+i];
            wb.rd_en = 1; wb.rd_ch = ch[1:0];
            @(posedge clk); #1;
            check("b_out_valid", wb.out_valid, 1'b1);
            check("b_out_ch",    wb.out_ch, ch[1:0]);
            check("b_weights",   wb.weights_out, bexp);
        end
        wb.rd_en = 0;

        // Instance C: CH=3, channel index 3 is out of range.
        for (int i = 0; i < 27; i++) begin
            wc.in_valid = 1; wc.in_data = bv[i][7:0];
            @(posedge clk); #1;
        end
        wc.in_valid = 0;
        check("c_full", wc.shadow_full, 1'b1);
        wc.swap = 1;
        @(posedge clk); #1;
        wc.swap = 0;
        wc.rd_en = 1; wc.rd_ch = 2'd3;
        @(posedge clk); #1;
        check("c_bad_ch_err", {wc.err, wc.out_valid}, 2'b10);
        for (int i = 0; i < 9; i++) cexp[i*8 +: 8] = bv[18+i][7:0];
        wc.rd_ch = 2'd2;
        @(posedge clk); #1;
        check("c_ch2", {wc.err, wc.out_valid, wc.out_ch}, 4'b0110);
        check("c_ch2_weights", wc.weights_out, cexp);
        wc.rd_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
